// File: rtl/ce_stream_source.sv
// Sample source for clock-enable filter interfaces: buffers host writes in a
// FIFO and releases them as single-cycle o_ce strobes at a programmable rate.
module ce_stream_source #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned DIV_WIDTH  = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     i_enable,
  input  logic [DIV_WIDTH-1:0]     i_div,
  input  logic                     i_wr_valid,
  input  logic [DATA_WIDTH-1:0]    i_wr_data,
  output logic                     o_wr_ready,
  output logic [DATA_WIDTH-1:0]    o_data,
  output logic                     o_ce,
  output logic                     o_underrun,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [DIV_WIDTH-1:0]  cnt;
  logic [LW-1:0]         level_next;
  logic                  tick;
  logic                  wr_fire;
  logic                  pop;
  logic                  empty;

  // Emptiness comes from the registered level, so a write landing on the
  // same edge as a tick cannot be popped until the following tick.
  always_comb begin
    tick       = i_enable && (cnt >= i_div);
    wr_fire    = i_wr_valid && o_wr_ready;
    empty      = (o_level == '0);
    pop        = tick && !empty;
    level_next = o_level;
    if (wr_fire && !pop)
      level_next = o_level + 1'b1;
    else if (pop && !wr_fire)
      level_next = o_level - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_fire)
      mem[wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (!i_enable || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_level    <= '0;
      o_wr_ready <= 1'b0;
      o_data     <= '0;
      o_ce       <= 1'b0;
      o_underrun <= 1'b0;
    end else begin
      if (wr_fire)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        o_data <= mem[rd_ptr];
      end
      o_level    <= level_next;
      o_wr_ready <= (level_next != LW'(DEPTH));
      o_ce       <= pop;
      o_underrun <= tick && empty;
    end
  end

endmodule

// File: tb/tb_ce_stream_source.sv
// Scenario bench for ce_stream_source: accepted writes feed a queue that is
// drained and compared whenever the source strobes o_ce.
module tb_ce_stream_source;

  logic       clk;
  logic       reset_n;
  logic       i_enable;
  logic [7:0] i_div;
  logic       i_wr_valid;
  logic [7:0] i_wr_data;
  logic       o_wr_ready;
  logic [7:0] o_data;
  logic       o_ce;
  logic       o_underrun;
  logic [4:0] o_level;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] sb [$];

  ce_stream_source #(.DATA_WIDTH(8), .DEPTH(16), .DIV_WIDTH(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_enable   (i_enable),
    .i_div      (i_div),
    .i_wr_valid (i_wr_valid),
    .i_wr_data  (i_wr_data),
    .o_wr_ready (o_wr_ready),
    .o_data     (o_data),
    .o_ce       (o_ce),
    .o_underrun (o_underrun),
    .o_level    (o_level)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  always @(negedge clk) begin
    logic [7:0] exp;
    if (o_ce === 1'b1) begin
      checks = checks + 1;
      if (sb.size() == 0) begin
        errors = errors + 1;
        $display("FAIL sb_extra: o_ce with o_data=%h but no sample expected", o_data);
      end else begin
        exp = sb.pop_front();
        if (o_data !== exp) begin
          errors = errors + 1;
          $display("FAIL sb_data: o_data=%h expected %h", o_data, exp);
        end
      end
    end
  end

  task automatic wr(input logic [7:0] d, input bit accept);
    i_wr_valid = 1'b1;
    i_wr_data  = d;
    if (accept) sb.push_back(d);
    @(negedge clk);
    i_wr_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; i_enable = 1'b0; i_div = '0;
    i_wr_valid = 1'b1; i_wr_data = 8'h55;
    repeat (3) @(negedge clk);
    checks = checks + 1;
    if ({o_data, o_ce, o_underrun, o_level, o_wr_ready} !== '0) begin
      errors = errors + 1;
      $display("FAIL reset_outputs: data=%h ce=%b ur=%b level=%0d ready=%b expected all 0",
               o_data, o_ce, o_underrun, o_level, o_wr_ready);
    end
    reset_n = 1'b1;
    @(negedge clk);
    checks = checks + 1;
    if (o_wr_ready !== 1'b1 || o_level !== 5'd0) begin
      errors = errors + 1;
      $display("FAIL reset_release: ready=%b level=%0d expected ready=1 level=0", o_wr_ready, o_level);
    end
    i_wr_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks = checks + 1;
    if (o_level !== 5'd0 || o_ce !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL reset_idle: level=%0d ce=%b expected 0 0", o_level, o_ce);
    end
  endtask

  task automatic test_rate_order();
    logic exp_ce, exp_ur;
    wr(8'h10, 1'b1); wr(8'h20, 1'b1); wr(8'h30, 1'b1);
    checks = checks + 1;
    if (o_level !== 5'd3) begin
      errors = errors + 1;
      $display("FAIL rate_level: level=%0d expected 3", o_level);
    end
    i_div = 8'd3; i_enable = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      exp_ce = (i % 4 == 0) && (i <= 12);
      exp_ur = (i == 16);
      checks = checks + 1;
      if (o_ce !== exp_ce || o_underrun !== exp_ur) begin
        errors = errors + 1;
        $display("FAIL rate_cycle%0d: ce=%b ur=%b expected ce=%b ur=%b", i, o_ce, o_underrun, exp_ce, exp_ur);
      end
    end
    checks = checks + 1;
    if (o_data !== 8'h30) begin
      errors = errors + 1;
      $display("FAIL rate_hold: o_data=%h expected 30", o_data);
    end
    i_enable = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) wr(8'(i), 1'b1);
    checks = checks + 1;
    if (o_level !== 5'd16 || o_wr_ready !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL b2b_fill: level=%0d ready=%b expected 16 0", o_level, o_wr_ready);
    end
    i_div = 8'd0; i_enable = 1'b1;
    for (int i = 1; i <= 18; i++) begin
      @(negedge clk);
      checks = checks + 1;
      if (i <= 16) begin
        if (o_ce !== 1'b1 || o_underrun !== 1'b0 || o_level !== 5'(16 - i)) begin
          errors = errors + 1;
          $display("FAIL b2b_pop%0d: ce=%b ur=%b level=%0d expected 1 0 %0d", i, o_ce, o_underrun, o_level, 16 - i);
        end
      end else if (o_ce !== 1'b0 || o_underrun !== 1'b1) begin
        errors = errors + 1;
        $display("FAIL b2b_under%0d: ce=%b ur=%b expected 0 1", i, o_ce, o_underrun);
      end
    end
    i_enable = 1'b0;
  endtask

  task automatic test_full();
    for (int i = 0; i < 17; i++) wr(8'h40 + 8'(i), i < 16);
    checks = checks + 1;
    if (o_level !== 5'd16 || o_wr_ready !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL full_level: level=%0d ready=%b expected 16 0", o_level, o_wr_ready);
    end
    i_div = 8'd0; i_enable = 1'b1;
    @(negedge clk);
    i_enable = 1'b0;
    checks = checks + 1;
    if (o_ce !== 1'b1 || o_level !== 5'd15 || o_wr_ready !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL full_tick: ce=%b level=%0d ready=%b expected 1 15 1", o_ce, o_level, o_wr_ready);
    end
    i_enable = 1'b1;
    repeat (17) @(negedge clk);
    i_enable = 1'b0;
    checks = checks + 1;
    if (sb.size() != 0 || o_level !== 5'd0) begin
      errors = errors + 1;
      $display("FAIL full_drain: pending=%0d level=%0d expected 0 0", sb.size(), o_level);
    end
    @(negedge clk);
  endtask

  task automatic test_div_change();
    logic exp_ur;
    i_div = 8'd7; i_enable = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      exp_ur = (i == 6) || (i == 8) || (i == 10);
      checks = checks + 1;
      if (o_underrun !== exp_ur || o_ce !== 1'b0) begin
        errors = errors + 1;
        $display("FAIL div_cycle%0d: ur=%b ce=%b expected ur=%b ce=0", i, o_underrun, o_ce, exp_ur);
      end
      if (i == 5) i_div = 8'd1;
    end
    i_enable = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit found;
    for (int i = 0; i < 5; i++) wr(8'h60 + 8'(i), 1'b1);
    i_div = 8'd1; i_enable = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (o_ce === 1'b1) found = 1'b1;
    end
    checks = checks + 1;
    if (!found || o_data !== 8'h60) begin
      errors = errors + 1;
      $display("FAIL mid_first: seen=%b o_data=%h expected seen=1 data=60", found, o_data);
    end
    #1 reset_n = 1'b0;
    #1;
    checks = checks + 1;
    if (o_ce !== 1'b0 || o_level !== 5'd0 || o_wr_ready !== 1'b0 || o_data !== 8'h00) begin
      errors = errors + 1;
      $display("FAIL mid_reset: ce=%b level=%0d ready=%b data=%h expected all 0",
               o_ce, o_level, o_wr_ready, o_data);
    end
    sb.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    wr(8'hAA, 1'b1);
    checks = checks + 1;
    if (o_underrun !== 1'b1 || o_ce !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL mid_race: ur=%b ce=%b expected 1 0", o_underrun, o_ce);
    end
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(negedge clk);
      if (o_ce === 1'b1) found = 1'b1;
    end
    checks = checks + 1;
    if (!found || o_data !== 8'hAA) begin
      errors = errors + 1;
      $display("FAIL mid_after: seen=%b o_data=%h expected seen=1 data=aa", found, o_data);
    end
    i_enable = 1'b0;
    @(negedge clk);
    checks = checks + 1;
    if (sb.size() != 0) begin
      errors = errors + 1;
      $display("FAIL mid_pending: pending=%0d expected 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_rate_order();
    test_back_to_back();
    test_full();
    test_div_change();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ce_stream_source.md
Name: ce_stream_source

Overview:
- Producer side of the clock-enable sample interface (strobe `ce` plus data bus) used by the filter blocks.
- Buffers host-written samples in a FIFO and emits them as single-cycle `o_ce` strobes at a programmable sample rate.
- Feeds filters such as average_filter (`o_ce`→`i_ce`, `o_data`→`data_in`) in benches and in the datapath.
- Reports FIFO occupancy and flags underrun when a sample slot arrives with no data.

Parameters:
- DATA_WIDTH, 8, sample width in bits.
- DEPTH, 16, FIFO depth in words; must be a power of 2, at least 2.
- DIV_WIDTH, 8, width of the rate divider control.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- i_enable  input  1  1 = strobe generation runs; 0 = divider held, no strobes.
- i_div  input  DIV_WIDTH  strobe period minus 1, in clk cycles.
- i_wr_valid  input  1  host presents a sample.
- i_wr_data  input  DATA_WIDTH  host sample.
- o_wr_ready  output  1  FIFO can accept a sample; a write occurs when valid and ready are both 1 at an edge.
- o_data  output  DATA_WIDTH  emitted sample; valid when o_ce=1, holds its value otherwise.
- o_ce  output  1  single-cycle sample strobe.
- o_underrun  output  1  single-cycle pulse: a slot was due but the FIFO was empty.
- o_level  output  $clog2(DEPTH)+1  FIFO occupancy, range 0..DEPTH.

Behaviour:
- Reset, asynchronous on reset_n low:
  - o_data=0, o_ce=0, o_underrun=0, o_level=0, o_wr_ready=0.
  - FIFO pointers cleared, divider counter cleared.
  - Writes are ignored while reset_n is low.
- First edge after reset release: o_wr_ready goes to 1.
- All outputs are registered.
- o_wr_ready = registered !full. When o_level==DEPTH it is 0, even if a pop occurs at the same edge. No write is lost or overwritten.
- Divider:
  - Counter cnt, DIV_WIDTH bits.
  - i_enable=0: cnt is forced to 0 and no tick occurs.
  - i_enable=1: at each edge, if cnt >= i_div, a tick occurs and cnt returns to 0; otherwise cnt increments.
  - Strobe period = i_div+1 cycles. i_div=0 gives a tick every cycle.
  - The >= comparison makes a lowered i_div take effect at the next edge.
- Tick with level>0:
  - Head word is popped.
  - o_data = head word and o_ce = 1 for exactly the following cycle.
  - o_ce is 0 at the next edge unless another tick pops.
- Tick with level==0: o_ce stays 0, o_underrun = 1 for one cycle, o_data unchanged.
- o_data changes only on a pop; between strobes it holds the last emitted sample.
- Level update per edge:
  - +1 on write only.
  - −1 on pop only.
  - Unchanged when write and pop happen at the same edge.
- Empty-FIFO race: emptiness is judged on the registered level. A write landing at the same edge as a tick on an empty FIFO still produces an underrun. The written word is emitted on the next tick.
- Ordering: strict FIFO; pointers wrap modulo DEPTH.
- Latency: a word written at edge k is first poppable at edge k+1. Minimum write-to-o_ce latency is therefore 1 cycle after the pop edge, i.e. o_ce is high in cycle k+1..k+2.
- Reset mid-operation:
  - Outputs drop immediately and the FIFO contents are discarded.
  - After release, the first emitted sample is the first post-reset write.

Test Plan:
- Reset: assert reset_n=0 with i_wr_valid=1 → all outputs 0. Release → o_wr_ready=1 after the first edge, o_level=0, no o_ce.
- Rate and order: write 0x10, 0x20, 0x30; i_div=3; i_enable=1 → o_ce every 4 cycles with o_data 0x10, 0x20, 0x30. Next tick: o_underrun pulse, no o_ce, o_data holds 0x30.
- Back-to-back: i_enable=0, write 16 words 0x00..0x0F; set i_div=0, i_enable=1 → 16 consecutive o_ce cycles with o_data 0x00..0x0F. o_level counts 16→0, then o_underrun pulses every cycle.
- Full: i_enable=0, 17 write attempts → o_level=16, o_wr_ready=0, 17th word not accepted. Single tick → o_level=15, o_wr_ready=1 next cycle. Emitted data shows the 17th word never entered.
- Divider change: i_div=7; when cnt=5 set i_div=1 → tick at the next edge, then a period of 2 cycles.
- Reset mid-stream: 5 words queued, o_ce active; pulse reset_n low → o_ce=0, o_level=0 immediately. Write 0xAA after release → next o_ce carries 0xAA.
